// File: rtl/mbist_march_ctrl_if.sv
// ---------------------------------------------------------------------------
// mbist_march_ctrl_if
// Purpose : bundles the start/status handshake and the memory bus of the
//           March C- MBIST controller into one interface.
// Signals : start          - level request to begin a test
//           busy/done      - test in progress / test finished
//           fail           - sticky mismatch flag
//           fail_addr/elem - address and March element of first mismatch
//           mem_write_read - 1 = write, 0 = read
//           mem_address    - memory address
//           mem_wdata      - memory write data
//           mem_rdata      - memory read data (two-cycle read latency)
// Modports: slave  - the controller's view
//           master - the host/memory side view
// ---------------------------------------------------------------------------
interface mbist_march_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  start;
    logic                  busy;
    logic                  done;
    logic                  fail;
    logic [ADDR_WIDTH-1:0] fail_addr;
    logic [2:0]            fail_elem;
    logic                  mem_write_read;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  start, mem_rdata,
        output busy, done, fail, fail_addr, fail_elem,
               mem_write_read, mem_address, mem_wdata
    );

    modport master (
        output start, mem_rdata,
        input  busy, done, fail, fail_addr, fail_elem,
               mem_write_read, mem_address, mem_wdata
    );
endinterface

// File: rtl/mbist_march_ctrl.sv
// ---------------------------------------------------------------------------
// mbist_march_ctrl
// Purpose : March C- memory BIST controller over addresses 0..LAST_ADDR.
//           Elements: up(w0); up(r0,w1); up(r1,w0); down(r0,w1);
//           down(r1,w0); up(r0). Read data is compared two cycles after the
//           read is issued, using a two-stage expected-value pipeline.
// Ports   : clk  - clock, rising edge
//           rst  - asynchronous active-high reset
//           bus  - mbist_march_ctrl_if.slave (handshake + memory bus)
// Config  : MBIST_FAIL_STOP_EN - when defined, the first mismatch ends the
//           test and the FSM goes straight to DONE; otherwise the test
//           always runs to completion with the first failure recorded.
// ---------------------------------------------------------------------------
module mbist_march_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int LAST_ADDR  = 15
) (
    input  logic              clk,
    input  logic              rst,
    mbist_march_ctrl_if.slave bus
);
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_RUN   = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic [ADDR_WIDTH-1:0] LAST_A = ADDR_WIDTH'(LAST_ADDR);

    function automatic logic elem_down(input logic [2:0] e);
        return (e == 3'd3) || (e == 3'd4);
    endfunction

    function automatic logic elem_rw(input logic [2:0] e);
        return (e >= 3'd1) && (e <= 3'd4);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] elem_wdata(input logic [2:0] e);
        return ((e == 3'd1) || (e == 3'd3)) ? '1 : '0;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] elem_rexp(input logic [2:0] e);
        return ((e == 3'd2) || (e == 3'd4)) ? '1 : '0;
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] first_addr(input logic [2:0] e);
        return elem_down(e) ? LAST_A : '0;
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] term_addr(input logic [2:0] e);
        return elem_down(e) ? '0 : LAST_A;
    endfunction

    logic [2:0]            state_q, state_d;
    logic [2:0]            elem_q, elem_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  phase_q, phase_d;   // 0 = read slot, 1 = write slot
    logic                  drain_q, drain_d;
    logic                  fail_q;
    logic [ADDR_WIDTH-1:0] fail_addr_q;
    logic [2:0]            fail_elem_q;

    logic                  vld_p0, vld_p1;
    logic [DATA_WIDTH-1:0] exp_p0, exp_p1;
    logic [ADDR_WIDTH-1:0] adr_p0, adr_p1;
    logic [2:0]            elm_p0, elm_p1;

    logic                  wr;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wd;
    logic                  start_acc;
    logic                  running;
    logic                  new_fail;
    logic                  rd_issue;

    assign start_acc = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && bus.start;
    assign running   = (state_q == ST_SETUP) || (state_q == ST_RUN) || (state_q == ST_DRAIN);
    // SETUP reads are dummy operations, so only RUN reads enter the pipeline.
    assign rd_issue  = (state_q == ST_RUN) && !wr;
    assign new_fail  = vld_p1 && (bus.mem_rdata != exp_p1) && !fail_q;

    always_comb begin
        wr       = 1'b0;
        mem_addr = '0;
        mem_wd   = '0;
        case (state_q)
            ST_SETUP: begin
                mem_addr = addr_q;
                mem_wd   = elem_wdata(elem_q);
            end
            ST_RUN: begin
                mem_addr = addr_q;
                mem_wd   = elem_wdata(elem_q);
                if (elem_q == 3'd0)
                    wr = 1'b1;
                else if (elem_rw(elem_q))
                    wr = phase_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        elem_d  = elem_q;
        addr_d  = addr_q;
        phase_d = phase_q;
        drain_d = drain_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    state_d = ST_SETUP;
                    elem_d  = 3'd0;
                    addr_d  = first_addr(3'd0);
                    phase_d = 1'b0;
                end
            end
            ST_SETUP: begin
                state_d = ST_RUN;
                phase_d = 1'b0;
            end
            ST_RUN: begin
                if (elem_rw(elem_q) && !phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    // The terminal address ends the element; counters never wrap.
                    if (addr_q == term_addr(elem_q)) begin
                        if (elem_q == 3'd5) begin
                            state_d = ST_DRAIN;
                            drain_d = 1'b0;
                        end else begin
                            state_d = ST_SETUP;
                            elem_d  = elem_q + 3'd1;
                            addr_d  = first_addr(elem_q + 3'd1);
                        end
                    end else if (elem_down(elem_q)) begin
                        addr_d = addr_q - ADDR_WIDTH'(1);
                    end else begin
                        addr_d = addr_q + ADDR_WIDTH'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_q)
                    state_d = ST_DONE;
                else
                    drain_d = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
`ifdef MBIST_FAIL_STOP_EN
        if (new_fail && running)
            state_d = ST_DONE;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            elem_q      <= 3'd0;
            addr_q      <= '0;
            phase_q     <= 1'b0;
            drain_q     <= 1'b0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_elem_q <= 3'd0;
            vld_p0      <= 1'b0;
            vld_p1      <= 1'b0;
        end else begin
            state_q <= state_d;
            elem_q  <= elem_d;
            addr_q  <= addr_d;
            phase_q <= phase_d;
            drain_q <= drain_d;
            // Stage p0: read issued; stage p1: data arrives next cycle.
            vld_p0  <= rd_issue;
            vld_p1  <= vld_p0 && !start_acc;
            if (start_acc) begin
                fail_q      <= 1'b0;
                fail_addr_q <= '0;
                fail_elem_q <= 3'd0;
            end else if (new_fail) begin
                fail_q      <= 1'b1;
                fail_addr_q <= adr_p1;
                fail_elem_q <= elm_p1;
            end
        end
    end

    always_ff @(posedge clk) begin
        exp_p0 <= elem_rexp(elem_q);
        adr_p0 <= addr_q;
        elm_p0 <= elem_q;
        exp_p1 <= exp_p0;
        adr_p1 <= adr_p0;
        elm_p1 <= elm_p0;
    end

    assign bus.busy           = running;
    assign bus.done           = (state_q == ST_DONE);
    assign bus.fail           = fail_q;
    assign bus.fail_addr      = fail_addr_q;
    assign bus.fail_elem      = fail_elem_q;
    assign bus.mem_write_read = wr;
    assign bus.mem_address    = mem_addr;
    assign bus.mem_wdata      = mem_wd;
endmodule

// File: tb/tb_mbist_march_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mbist_march_ctrl
// Drives the March C- controller against a behavioural memory with a
// two-cycle read latency and an optional stuck-at fault on one address.
// ---------------------------------------------------------------------------
module tb_mbist_march_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mbist_march_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

    mbist_march_ctrl #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(4),
        .LAST_ADDR (15)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [7:0] mem [16];
    logic [7:0] rd_p0, rd_p1;
    logic [3:0] fa_v;
    logic [7:0] s1_v, s0_v;

    always @(posedge clk) begin
        if (bus.mem_write_read)
            mem[bus.mem_address] <= bus.mem_wdata;
        if (bus.mem_address == fa_v)
            rd_p0 <= (mem[bus.mem_address] | s1_v) & ~s0_v;
        else
            rd_p0 <= mem[bus.mem_address];
        rd_p1 <= rd_p0;
    end
    assign bus.mem_rdata = rd_p1;

    typedef struct {
        logic [3:0] fa;
        logic [7:0] s1;
        logic [7:0] s0;
        int         hold;
        logic       xfail;
        logic [3:0] xaddr;
        logic [2:0] xelem;
    } vec_t;

    typedef struct {
        logic       wr;
        logic [3:0] addr;
        logic [7:0] wdata;
        logic       full;
    } op_t;

    op_t  sb_q[$];
    vec_t vecs[7];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    // Independent March C- model: one queue entry per busy cycle.
    task automatic build_expected(input logic [3:0] fa, input logic [7:0] s1,
                                  input logic [7:0] s0, output int busy_exp);
        logic [7:0] m [16];
        int k;
        int first;
        logic dn;
        logic [7:0] wv, rv, rd;
        logic [3:0] a;
        k = 0;
        first = -1;
        sb_q.delete();
        for (int e = 0; e < 6; e++) begin
            dn = (e == 3) || (e == 4);
            wv = ((e == 1) || (e == 3)) ? 8'hFF : 8'h00;
            rv = ((e == 2) || (e == 4)) ? 8'hFF : 8'h00;
            sb_q.push_back('{1'b0, dn ? 4'd15 : 4'd0, wv, 1'b1});
            k++;
            for (int i = 0; i < 16; i++) begin
                a = dn ? 4'(15 - i) : 4'(i);
                if (e > 0) begin
                    sb_q.push_back('{1'b0, a, wv, 1'b1});
                    rd = (a == fa) ? ((m[a] | s1) & ~s0) : m[a];
                    if (first < 0 && rd != rv) first = k;
                    k++;
                end
                if (e < 5) begin
                    sb_q.push_back('{1'b1, a, wv, 1'b1});
                    m[a] = wv;
                    k++;
                end
            end
        end
        sb_q.push_back('{1'b0, 4'd0, 8'd0, 1'b0});
        sb_q.push_back('{1'b0, 4'd0, 8'd0, 1'b0});
        busy_exp = k + 2;
`ifdef MBIST_FAIL_STOP_EN
        if (first >= 0) begin
            busy_exp = first + 3;
            while (sb_q.size() > busy_exp) void'(sb_q.pop_back());
        end
`endif
    endtask

    task automatic run_case(input int idx, input vec_t v);
        int busy_exp;
        int busy_cnt;
        op_t e;
        logic [12:0] g13, x13;
        fa_v = v.fa;
        s1_v = v.s1;
        s0_v = v.s0;
        build_expected(v.fa, v.s1, v.s0, busy_exp);
        bus.start = 1'b1;
        busy_cnt = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (c >= v.hold) bus.start = 1'b0;
            if (c == 0) begin
                chk($sformatf("v%0d_done_cleared", idx), bus.done, 0);
                chk($sformatf("v%0d_fail_cleared", idx), bus.fail, 0);
            end
            if (!bus.busy) break;
            busy_cnt++;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                x13 = {e.wr, e.full ? {e.addr, e.wdata} : 12'h000};
                g13 = {bus.mem_write_read,
                       e.full ? {bus.mem_address, bus.mem_wdata} : 12'h000};
                chk($sformatf("v%0d_op_c%0d", idx, c), g13, x13);
            end
        end
        bus.start = 1'b0;
        chk($sformatf("v%0d_busy_cycles", idx), busy_cnt, busy_exp);
        chk($sformatf("v%0d_ops_left", idx), sb_q.size(), 0);
        chk($sformatf("v%0d_done", idx), bus.done, 1);
        chk($sformatf("v%0d_fail", idx), bus.fail, v.xfail);
        chk($sformatf("v%0d_fail_addr", idx), bus.fail_addr, v.xaddr);
        chk($sformatf("v%0d_fail_elem", idx), bus.fail_elem, v.xelem);
        chk($sformatf("v%0d_done_bus", idx),
            {bus.mem_write_read, bus.mem_address, bus.mem_wdata}, 0);
        @(negedge clk);
        chk($sformatf("v%0d_done_sticky", idx), {bus.done, bus.busy}, 2'b10);
    endtask

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        fa_v      = 4'd0;
        s1_v      = 8'h00;
        s0_v      = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_status", {bus.busy, bus.done, bus.fail}, 0);
        chk("rst_fail_info", {bus.fail_addr, bus.fail_elem}, 0);
        chk("rst_bus", {bus.mem_write_read, bus.mem_address, bus.mem_wdata}, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_status", {bus.busy, bus.done, bus.fail}, 0);

        vecs[0] = '{4'd0,  8'h00, 8'h00, 0,   1'b0, 4'd0,  3'd0};
        vecs[1] = '{4'd9,  8'h01, 8'h00, 0,   1'b1, 4'd9,  3'd1};
        vecs[2] = '{4'd3,  8'h00, 8'h80, 0,   1'b1, 4'd3,  3'd2};
        vecs[3] = '{4'd0,  8'h00, 8'h00, 100, 1'b0, 4'd0,  3'd0};
        vecs[4] = '{4'd0,  8'h80, 8'h00, 0,   1'b1, 4'd0,  3'd1};
        vecs[5] = '{4'd15, 8'h00, 8'h01, 0,   1'b1, 4'd15, 3'd2};
        vecs[6] = '{4'd6,  8'h00, 8'h10, 0,   1'b1, 4'd6,  3'd2};

        for (int i = 0; i < 7; i++) run_case(i, vecs[i]);

        // Reset in the middle of a faulty run, then a clean run.
        fa_v = 4'd9;
        s1_v = 8'h01;
        s0_v = 8'h00;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (50) @(negedge clk);
        chk("mid_fail_before_rst", bus.fail, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_status", {bus.busy, bus.done, bus.fail}, 0);
        chk("mid_rst_fail_info", {bus.fail_addr, bus.fail_elem}, 0);
        chk("mid_rst_bus", {bus.mem_write_read, bus.mem_address, bus.mem_wdata}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_case(7, vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mbist_march_ctrl.md
MBIST_MARCH_CTRL -- requirements
Module: mbist_march_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8, memory word width.
REQ-002 Parameter ADDR_WIDTH, default 4, memory address width.
REQ-003 Parameter LAST_ADDR, default 15, highest address tested; the range is 0..LAST_ADDR.
REQ-004 clk  input  1  sole clock; all state changes on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  level-sampled request to begin a test.
REQ-007 busy  output  1  high while a test is in progress.
REQ-008 done  output  1  high from test end until the next accepted start.
REQ-009 fail  output  1  sticky; high once any read compare mismatches.
REQ-010 fail_addr  output  ADDR_WIDTH  address of the first mismatch.
REQ-011 fail_elem  output  3  March element index (0-5) of the first mismatch.
REQ-012 mem_write_read  output  1  memory control; 1 = write, 0 = read.
REQ-013 mem_address  output  ADDR_WIDTH  memory address.
REQ-014 mem_wdata  output  DATA_WIDTH  memory write data.
REQ-015 mem_rdata  input  DATA_WIDTH  memory read data.

Function
REQ-016 The block SHALL run March C- elements 0-5, in order: up(w0); up(r0,w1); up(r1,w0); down(r0,w1); down(r1,w0); up(r0). Data 0 is all-zeros; data 1 is all-ones.
REQ-017 The FSM SHALL have states IDLE, SETUP, RUN, DRAIN and DONE.
REQ-018 IDLE or DONE with start=1 SHALL go to SETUP, element 0; this clears done, fail, fail_addr and fail_elem.
REQ-019 SETUP SHALL last exactly 1 cycle per element:
- mem_write_read=0, read result discarded.
- mem_wdata = the element's write data.
- mem_address = the element's first address (0 for up, LAST_ADDR for down).
REQ-020 mem_wdata SHALL hold the element's write data for the whole element, so data is stable one cycle before each write, as the memory's registered write-data path requires.
REQ-021 RUN SHALL issue exactly one operation per cycle:
- For read-then-write elements, address A gets a read then a write before advancing.
- Up elements run 0..LAST_ADDR; down elements run LAST_ADDR..0.
REQ-022 After the last operation of an element, the FSM SHALL go to SETUP of the next element; after element 5 it SHALL go to DRAIN.
REQ-023 DRAIN SHALL last 2 cycles with mem_write_read=0, then go to DONE.
REQ-024 Read data SHALL be compared 2 cycles after the read is issued, against the expected value, address and element delayed through a 2-stage pipeline.
REQ-025 On the first mismatch, the block SHALL set fail and capture fail_addr and fail_elem; later mismatches SHALL NOT overwrite them.
REQ-026 start while busy SHALL be ignored.
REQ-027 With LAST_ADDR=15, a run SHALL take 168 cycles (6 SETUP + 160 RUN + 2 DRAIN); busy=1 for exactly those cycles.
REQ-028 Address counters SHALL NOT wrap past 0 or LAST_ADDR; the terminal address ends the element.
REQ-029 In IDLE and DONE: mem_write_read=0, mem_address=0, mem_wdata=0.

Reset
REQ-030 rst SHALL force IDLE immediately, including mid-test, and clear the compare pipeline.
REQ-031 Reset values SHALL be: busy=0, done=0, fail=0, fail_addr=0, fail_elem=0, mem_write_read=0, mem_address=0, mem_wdata=0.

Configuration
REQ-032 Macro MBIST_FAIL_STOP_EN:
- Defined: the first mismatch SHALL end the test; the FSM goes directly to DONE the next cycle and drops busy.
- Undefined: the test SHALL always run to completion, with the first failure recorded.

Verification
REQ-033 Fault-free memory, LAST_ADDR=15, start pulse -> busy 168 cycles, then done=1, fail=0.
REQ-034 Address 9 bit 0 stuck-at-1 -> fail=1, fail_addr=9, fail_elem=1; without the macro, done after 168 cycles.
REQ-035 Same fault with MBIST_FAIL_STOP_EN -> done asserted the cycle after the mismatch compare; busy=0; 168-cycle count not reached.
REQ-036 rst asserted at cycle 50 of a run -> all outputs 0 immediately; a new start gives a full 168-cycle fault-free run.
REQ-037 start held high during a run -> run length unchanged; start after done -> fail/done cleared and a new run starts.
REQ-038 Address 3 bit 7 stuck-at-0 -> fail_addr=3, fail_elem=2 (first r1); write cycles show mem_wdata stable one cycle before mem_write_read=1.
